// File: rtl/pos_dac_tx.sv
// pos_dac_tx: shifts 16-bit position-PID words to an external SPI-style DAC.
// Each word goes out as a 24-bit frame {CMD_WORD, data}, MSB first. SCLK idles
// high, and the DAC samples SDO on SCLK falling edges. A one-word pending slot
// holds an update that arrives while a frame is in flight.
//
// state | meaning
// IDLE  | no frame in flight; SCLK high, SYNC_N high
// SHIFT | frame active; 24 bits, each CLK_DIV cycles high then CLK_DIV cycles low
// GAP   | SYNC_N held high for GAP_CYC cycles before the next frame may start
module pos_dac_tx #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned GAP_CYC  = 2,
    parameter logic [7:0]  CMD_WORD = 8'h00
) (
    input  logic        clk_pid,
    input  logic        sys_rstn,
    input  logic [15:0] dac_data,
    input  logic        dac_valid,
    output logic        dac_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        dac_sclk,
    output logic        dac_sync_n,
    output logic        dac_sdo
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t            state;
    logic [22:0]       shreg;       // bits still to be sent after the one on dac_sdo
    logic [4:0]        bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              pend_full;
    logic [15:0]       pend_data;

    logic              xfer;
    logic              gap_last;
    logic              launch;
    logic              launch_pend;
    logic              pend_set;
    logic              pend_next;
    logic              idle_next;
    logic [23:0]       launch_word;

    // Handshake and frame-launch decisions for this cycle.
    always_comb begin
        xfer        = dac_valid & dac_ready;
        gap_last    = (state == GAP) && (gap_cnt == '0);
        // ready is low whenever the slot is full, so xfer and launch_pend never coincide
        launch_pend = gap_last && pend_full;
        launch      = ((state == IDLE) && xfer) || (gap_last && (pend_full || xfer));
        pend_set    = xfer && ((state == SHIFT) || ((state == GAP) && !gap_last));
        pend_next   = pend_set | (pend_full & ~launch_pend);
        idle_next   = ((state == IDLE) && !xfer) || (gap_last && !pend_full && !xfer);
        launch_word = {CMD_WORD, (launch_pend ? pend_data : dac_data)};
    end

    // Frame sequencer, pending slot and registered pin outputs.
    always_ff @(posedge clk_pid) begin
        if (!sys_rstn) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            pend_full  <= 1'b0;
            pend_data  <= '0;
            dac_ready  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            dac_sclk   <= 1'b1;
            dac_sync_n <= 1'b1;
            dac_sdo    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            pend_full  <= pend_next;
            dac_ready  <= ~pend_next;
            busy       <= pend_next | ~idle_next;
            if (pend_set) begin
                pend_data <= dac_data;
            end
            if (launch) begin
                state      <= SHIFT;
                dac_sdo    <= launch_word[23];
                shreg      <= launch_word[22:0];
                dac_sclk   <= 1'b1;
                dac_sync_n <= 1'b0;
                bit_cnt    <= 5'd23;
                div_cnt    <= DIV_LOAD;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    SHIFT: begin
                        if (div_cnt != '0) begin
                            div_cnt <= div_cnt - DIV_W'(1);
                        end else begin
                            div_cnt <= DIV_LOAD;
                            if (dac_sclk) begin
                                dac_sclk <= 1'b0;
                            end else if (bit_cnt == 5'd0) begin
                                state      <= GAP;
                                gap_cnt    <= GAP_LOAD;
                                dac_sync_n <= 1'b1;
                                dac_sclk   <= 1'b1;
                                dac_sdo    <= 1'b0;
                                frame_done <= 1'b1;
                            end else begin
                                // new bit is presented together with the sclk rising edge
                                bit_cnt  <= bit_cnt - 5'd1;
                                dac_sdo  <= shreg[22];
                                shreg    <= {shreg[21:0], 1'b0};
                                dac_sclk <= 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pos_dac_tx.sv
// Directed bench for pos_dac_tx: a CLK_DIV=2 instance and a CLK_DIV=1/CMD=8'h30
// instance share clock and reset; a pin-level receiver decodes each frame.
module tb_pos_dac_tx;

    logic        clk_pid = 1'b0;
    logic        sys_rstn;
    logic [15:0] data0, data1;
    logic        valid0, valid1;
    logic        ready0, busy0, fd0, sclk0, sync0, sdo0;
    logic        ready1, busy1, fd1, sclk1, sync1, sdo1;

    always #5 clk_pid = ~clk_pid;

    pos_dac_tx #(.CLK_DIV(2), .GAP_CYC(2), .CMD_WORD(8'h00)) dut (
        .clk_pid(clk_pid), .sys_rstn(sys_rstn), .dac_data(data0), .dac_valid(valid0),
        .dac_ready(ready0), .busy(busy0), .frame_done(fd0), .dac_sclk(sclk0),
        .dac_sync_n(sync0), .dac_sdo(sdo0));

    pos_dac_tx #(.CLK_DIV(1), .GAP_CYC(2), .CMD_WORD(8'h30)) dut1 (
        .clk_pid(clk_pid), .sys_rstn(sys_rstn), .dac_data(data1), .dac_valid(valid1),
        .dac_ready(ready1), .busy(busy1), .frame_done(fd1), .dac_sclk(sclk1),
        .dac_sync_n(sync1), .dac_sdo(sdo1));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk_pid) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] data;
        int          nbits;
        int          len;
        int          start;
    } frame_t;

    frame_t      fq0[$];
    frame_t      fq1[$];
    logic [1:0]  pv_s = 2'b11;
    logic [1:0]  pv_y = 2'b11;
    logic [23:0] sh[2];
    int          nb[2], ln[2], st[2], fd_cnt[2], fd_last[2], viol[2];

    initial begin
        for (int m = 0; m < 2; m++) begin
            sh[m] = '0; nb[m] = 0; ln[m] = 0; st[m] = 0;
            fd_cnt[m] = 0; fd_last[m] = 0; viol[m] = 0;
        end
    end

    // Pin-level receiver: captures sdo on sclk falls while sync_n is low.
    always @(negedge clk_pid) begin
        logic [1:0] s, y, d, f;
        frame_t     r;
        s = {sclk1, sclk0};
        y = {sync1, sync0};
        d = {sdo1, sdo0};
        f = {fd1, fd0};
        if (cyc > 2) begin
            for (int m = 0; m < 2; m++) begin
                if (y[m] == 1'b0) begin
                    if (pv_y[m]) begin
                        st[m] = cyc; nb[m] = 0; ln[m] = 0; sh[m] = '0;
                    end
                    ln[m]++;
                    if (pv_s[m] && !s[m]) begin
                        sh[m] = {sh[m][22:0], d[m]};
                        nb[m]++;
                    end
                end else if (!pv_y[m]) begin
                    r.data = sh[m]; r.nbits = nb[m]; r.len = ln[m]; r.start = st[m];
                    if (m == 0) fq0.push_back(r);
                    else        fq1.push_back(r);
                end else if (s[m] != pv_s[m]) begin
                    viol[m]++;
                end
                if (f[m]) begin
                    fd_cnt[m]++;
                    fd_last[m] = cyc;
                end
            end
        end
        pv_s = s;
        pv_y = y;
    end

    int          t, fdb, idx, nrdy, acc, mism;
    int          acc_c[3];
    logic [15:0] words[3];
    logic [23:0] sb[$];
    frame_t      r;

    task automatic pop0(output frame_t fr);
        if (fq0.size() > 0) fr = fq0.pop_front();
        else begin fr.data = 'x; fr.nbits = -1; fr.len = -1; fr.start = -1; end
    endtask

    task automatic pop1(output frame_t fr);
        if (fq1.size() > 0) fr = fq1.pop_front();
        else begin fr.data = 'x; fr.nbits = -1; fr.len = -1; fr.start = -1; end
    endtask

    initial begin
        sys_rstn = 1'b0;
        valid0 = 1'b0; valid1 = 1'b0;
        data0 = '0; data1 = '0;
        repeat (4) @(negedge clk_pid);
        check("rst_sclk",  32'(sclk0), 1);
        check("rst_sync",  32'(sync0), 1);
        check("rst_sdo",   32'(sdo0),  0);
        check("rst_ready", 32'(ready0), 0);
        check("rst_busy",  32'(busy0), 0);
        check("rst_done",  32'(fd0),   0);
        sys_rstn = 1'b1;
        @(negedge clk_pid);
        check("ready_after_rst", 32'(ready0), 1);

        // 1: single word, full timing
        t = cyc; fdb = fd_cnt[0]; nrdy = 0;
        data0 = 16'hA5C3; valid0 = 1'b1;
        @(negedge clk_pid);
        valid0 = 1'b0; data0 = 16'hFFFF;
        for (int i = 0; i < 110; i++) begin
            if (ready0 !== 1'b1) nrdy++;
            if (cyc == t + 50) check("t1_busy_mid", 32'(busy0), 1);
            @(negedge clk_pid);
        end
        check("t1_nframes", fq0.size(), 1);
        pop0(r);
        check("t1_data",  32'(r.data), 32'h00A5C3);
        check("t1_nbits", r.nbits, 24);
        check("t1_len",   r.len, 96);
        check("t1_start", r.start, t + 1);
        check("t1_done_count", fd_cnt[0] - fdb, 1);
        check("t1_done_cycle", fd_last[0], t + 97);
        check("t1_ready_drops", nrdy, 0);
        check("t1_busy_end", 32'(busy0), 0);

        // 2: valid held high across three words
        words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'hFFFF;
        acc_c[0] = -1; acc_c[1] = -1; acc_c[2] = -1;
        t = cyc; idx = 0;
        for (int i = 0; i < 450 && fq0.size() < 3; i++) begin
            if (idx < 3) begin
                valid0 = 1'b1; data0 = words[idx];
                if (ready0) begin acc_c[idx] = cyc; idx++; end
            end else begin
                valid0 = 1'b0;
            end
            @(negedge clk_pid);
        end
        valid0 = 1'b0;
        check("t2_acc0", acc_c[0], t);
        check("t2_acc1", acc_c[1], t + 1);
        check("t2_acc2", acc_c[2], t + 99);
        check("t2_nframes", fq0.size(), 3);
        pop0(r); check("t2_f0_data", 32'(r.data), 32'h000001); check("t2_f0_start", r.start, t + 1);
        pop0(r); check("t2_f1_data", 32'(r.data), 32'h008000); check("t2_f1_start", r.start, t + 99);
        pop0(r); check("t2_f2_data", 32'(r.data), 32'h00FFFF); check("t2_f2_start", r.start, t + 197);
        check("t2_f2_len", r.len, 96);
        repeat (5) @(negedge clk_pid);

        // 3: reset during bit 10 with a word pending
        t = cyc;
        valid0 = 1'b1; data0 = 16'hBEEF;
        @(negedge clk_pid);
        data0 = 16'h5555;
        @(negedge clk_pid);
        valid0 = 1'b0;
        check("t3_ready_pending", 32'(ready0), 0);
        repeat (53) @(negedge clk_pid);
        fdb = fd_cnt[0];
        sys_rstn = 1'b0;
        @(negedge clk_pid);
        check("t3_sync",  32'(sync0),  1);
        check("t3_sclk",  32'(sclk0),  1);
        check("t3_sdo",   32'(sdo0),   0);
        check("t3_ready", 32'(ready0), 0);
        check("t3_busy",  32'(busy0),  0);
        check("t3_done",  32'(fd0),    0);
        repeat (2) @(negedge clk_pid);
        sys_rstn = 1'b1;
        @(negedge clk_pid);
        check("t3_no_done", fd_cnt[0] - fdb, 0);
        fq0.delete();
        check("t3_ready_rel", 32'(ready0), 1);
        valid0 = 1'b1; data0 = 16'h1234;
        @(negedge clk_pid);
        valid0 = 1'b0;
        repeat (300) @(negedge clk_pid);
        check("t3_nframes", fq0.size(), 1);
        pop0(r);
        check("t3_data", 32'(r.data), 32'h001234);

        // 5: data toggling while ready is low is ignored
        valid0 = 1'b1; data0 = 16'h1111;
        @(negedge clk_pid);
        data0 = 16'h2222;
        @(negedge clk_pid);
        for (int i = 0; i < 200; i++) begin
            data0 = 16'($urandom);
            if (ready0) begin valid0 = 1'b0; break; end
            @(negedge clk_pid);
        end
        valid0 = 1'b0;
        repeat (250) @(negedge clk_pid);
        check("t5_nframes", fq0.size(), 2);
        pop0(r); check("t5_f0_data", 32'(r.data), 32'h001111);
        pop0(r); check("t5_f1_data", 32'(r.data), 32'h002222);

        // 4: CLK_DIV=1, CMD=8'h30
        fq1.delete();
        t = cyc;
        valid1 = 1'b1; data1 = 16'h0000;
        @(negedge clk_pid);
        data1 = 16'hFFFF;
        @(negedge clk_pid);
        valid1 = 1'b0;
        for (int i = 0; i < 200 && fq1.size() < 2; i++) @(negedge clk_pid);
        check("t4_nframes", fq1.size(), 2);
        pop1(r); check("t4_f0_data", 32'(r.data), 32'h300000);
        check("t4_f0_len", r.len, 48); check("t4_f0_start", r.start, t + 1);
        pop1(r); check("t4_f1_data", 32'(r.data), 32'h30FFFF);
        check("t4_f1_len", r.len, 48); check("t4_f1_start", r.start, t + 51);
        check("t4_f1_nbits", r.nbits, 24);
        repeat (5) @(negedge clk_pid);

        // 6: random words with random valid gaps against a scoreboard
        fq1.delete(); sb.delete();
        acc = 0; fdb = fd_cnt[1];
        for (int i = 0; i < 40000 && acc < 500; i++) begin
            valid1 = ($urandom_range(0, 3) != 0);
            data1  = 16'($urandom);
            if (valid1 && ready1) begin
                sb.push_back({8'h30, data1});
                acc++;
            end
            @(negedge clk_pid);
        end
        valid1 = 1'b0;
        for (int i = 0; i < 300 && fq1.size() < acc; i++) @(negedge clk_pid);
        repeat (5) @(negedge clk_pid);
        check("t6_accepted", acc, 500);
        check("t6_nframes", fq1.size(), acc);
        check("t6_done_count", fd_cnt[1] - fdb, acc);
        mism = 0;
        for (int i = 0; i < acc && fq1.size() > 0; i++) begin
            pop1(r);
            if (r.data !== sb[i] || r.nbits != 24 || r.len != 48) mism++;
        end
        check("t6_scoreboard", mism, 0);
        check("sclk_idle_0", viol[0], 0);
        check("sclk_idle_1", viol[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
